// File: rtl/bp_pred_meta_queue.sv
// Circular queue holding per-fetch-block global/local predictor outcomes until the
// branch resolves in order, then emits one registered update bundle for the choice predictor.
module bp_pred_meta_queue #(
    parameter int unsigned VLEN            = 32,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter bit          DebugEn         = 1'b1,
    parameter type bht_update_t = struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    },
    parameter type bht_prediction_t = struct packed {
        logic valid;
        logic taken;
    },
    parameter int unsigned DEPTH           = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic                                    debug_mode_i,
    input  logic                                    push_valid_i,
    output logic                                    push_ready_o,
    input  logic [VLEN-1:0]                         push_pc_i,
    input  bht_prediction_t [INSTR_PER_FETCH-1:0]   push_gbp_pred_i,
    input  bht_prediction_t [INSTR_PER_FETCH-1:0]   push_lbp_pred_i,
    input  logic                                    push_unaligned_i,
    input  logic                                    resolve_valid_i,
    input  logic [VLEN-1:0]                         resolve_pc_i,
    input  logic                                    resolve_taken_i,
    output bht_update_t                             bht_update_o,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]   update_gbp_pred_o,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]   update_lbp_pred_o,
    output logic                                    update_is_unaligned_o,
    output logic [$clog2(DEPTH):0]                  count_o,
    output logic                                    mismatch_o,
    output logic                                    underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage is intentionally left unreset; only pointers define occupancy.
    logic [VLEN-1:0]                       pc_mem    [DEPTH];
    bht_prediction_t [INSTR_PER_FETCH-1:0] gbp_mem   [DEPTH];
    bht_prediction_t [INSTR_PER_FETCH-1:0] lbp_mem   [DEPTH];
    logic                                  unal_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    bht_update_t                           upd_q;
    bht_prediction_t [INSTR_PER_FETCH-1:0] gbp_q, lbp_q;
    logic                                  unal_q;
    logic                                  mismatch_q, underflow_q;

    logic push_fire, pop_fire, pc_match, valid_d, mismatch_d, underflow_d;
    logic not_empty;

    assign not_empty    = (count_q != '0);
    assign push_ready_o = (count_q != CNT_W'(DEPTH));
    assign push_fire    = push_valid_i & push_ready_o & ~flush_i;
    assign pop_fire     = resolve_valid_i & not_empty & ~flush_i;
    assign pc_match     = (resolve_pc_i == pc_mem[rd_ptr_q]);
    assign valid_d      = pop_fire & pc_match & ~(DebugEn & debug_mode_i);
    assign mismatch_d   = pop_fire & ~pc_match;
    assign underflow_d  = resolve_valid_i & ~not_empty & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap naturally.
            if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            pc_mem[wr_ptr_q]   <= push_pc_i;
            gbp_mem[wr_ptr_q]  <= push_gbp_pred_i;
            lbp_mem[wr_ptr_q]  <= push_lbp_pred_i;
            unal_mem[wr_ptr_q] <= push_unaligned_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            upd_q       <= '0;
            gbp_q       <= '0;
            lbp_q       <= '0;
            unal_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mismatch_q  <= mismatch_d;
            underflow_q <= underflow_d;
            upd_q.valid <= valid_d;
            // Payload only moves on a pop; otherwise it holds as don't-care.
            if (pop_fire) begin
                upd_q.pc    <= pc_mem[rd_ptr_q];
                upd_q.taken <= resolve_taken_i;
                gbp_q       <= gbp_mem[rd_ptr_q];
                lbp_q       <= lbp_mem[rd_ptr_q];
                unal_q      <= unal_mem[rd_ptr_q];
            end
        end
    end

    assign bht_update_o          = upd_q;
    assign update_gbp_pred_o     = gbp_q;
    assign update_lbp_pred_o     = lbp_q;
    assign update_is_unaligned_o = unal_q;
    assign count_o               = count_q;
    assign mismatch_o            = mismatch_q;
    assign underflow_o           = underflow_q;

endmodule

// File: tb/tb_bp_pred_meta_queue.sv
// Directed and randomized checks of bp_pred_meta_queue against a queue-based reference model.
module tb_bp_pred_meta_queue;

    localparam int VLEN   = 32;
    localparam int IPF    = 2;
    localparam int DEPTH  = 8;
    localparam bit DBG_EN = 1'b1;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int PW     = 2 * IPF;
    localparam int OW     = (VLEN + 2) + 2 * PW + 1 + CW + 3;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } upd_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } pred_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [PW-1:0]   g;
        logic [PW-1:0]   l;
        logic            un;
    } ent_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0, debug_mode_i = 1'b0;
    logic push_valid_i = 1'b0, push_ready_o;
    logic [VLEN-1:0] push_pc_i = '0;
    pred_t [IPF-1:0] push_gbp_pred_i = '0, push_lbp_pred_i = '0;
    logic push_unaligned_i = 1'b0;
    logic resolve_valid_i = 1'b0;
    logic [VLEN-1:0] resolve_pc_i = '0;
    logic resolve_taken_i = 1'b0;
    upd_t bht_update_o;
    pred_t [IPF-1:0] update_gbp_pred_o, update_lbp_pred_o;
    logic update_is_unaligned_o;
    logic [CW-1:0] count_o;
    logic mismatch_o, underflow_o;

    bp_pred_meta_queue #(
        .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .DebugEn(DBG_EN),
        .bht_update_t(upd_t), .bht_prediction_t(pred_t), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
        .push_gbp_pred_i(push_gbp_pred_i), .push_lbp_pred_i(push_lbp_pred_i),
        .push_unaligned_i(push_unaligned_i), .resolve_valid_i(resolve_valid_i),
        .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
        .bht_update_o(bht_update_o), .update_gbp_pred_o(update_gbp_pred_o),
        .update_lbp_pred_o(update_lbp_pred_o), .update_is_unaligned_o(update_is_unaligned_o),
        .count_o(count_o), .mismatch_o(mismatch_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    ent_t          model_q[$];
    upd_t          e_upd = '0;
    logic [PW-1:0] e_gbp = '0, e_lbp = '0;
    logic          e_unal = 1'b0, e_mis = 1'b0, e_und = 1'b0, e_rdy = 1'b1;
    logic [CW-1:0] e_cnt = '0;

    logic [OW-1:0] obs, expv;
    assign obs  = {bht_update_o, update_gbp_pred_o, update_lbp_pred_o, update_is_unaligned_o,
                   count_o, mismatch_o, underflow_o, push_ready_o};
    assign expv = {e_upd, e_gbp, e_lbp, e_unal, e_cnt, e_mis, e_und, e_rdy};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        model_q.delete();
        e_upd = '0; e_gbp = '0; e_lbp = '0; e_unal = 1'b0;
        e_mis = 1'b0; e_und = 1'b0; e_cnt = '0; e_rdy = 1'b1;
    endtask

    // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
    task automatic step(input logic push, input logic [VLEN-1:0] ppc, input logic [PW-1:0] g,
                        input logic [PW-1:0] l, input logic un, input logic res,
                        input logic [VLEN-1:0] rpc, input logic tk, input logic dbg,
                        input logic fl);
        ent_t h;
        logic rdy;
        push_valid_i = push; push_pc_i = ppc; push_gbp_pred_i = g; push_lbp_pred_i = l;
        push_unaligned_i = un; resolve_valid_i = res; resolve_pc_i = rpc;
        resolve_taken_i = tk; debug_mode_i = dbg; flush_i = fl;
        rdy = (model_q.size() != DEPTH);
        e_upd.valid = 1'b0; e_mis = 1'b0; e_und = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (res && model_q.size() != 0) begin
                h = model_q.pop_front();
                e_upd.pc = h.pc; e_upd.taken = tk;
                e_gbp = h.g; e_lbp = h.l; e_unal = h.un;
                e_upd.valid = (h.pc == rpc) && !(DBG_EN && dbg);
                e_mis = (h.pc != rpc);
            end else if (res) begin
                e_und = 1'b1;
            end
            if (push && rdy) model_q.push_back('{pc: ppc, g: g, l: l, un: un});
        end
        e_cnt = CW'(model_q.size());
        e_rdy = (model_q.size() != DEPTH);
        @(posedge clk_i);
        #1;
        $display("[TB] t=%0t push=%0b res=%0b flush=%0b dbg=%0b -> valid=%0b pc=%h cnt=%0d mis=%0b und=%0b",
                 $time, push, res, fl, dbg, bht_update_o.valid, bht_update_o.pc, count_o,
                 mismatch_o, underflow_o);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        n_tests++;
        if (obs !== OW'(1)) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", obs, OW'(1));
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
        n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL reset_idle: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++)
            step(1'b1, VLEN'(32'h100 + 4 * i), 4'b1111, 4'b1010, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (count_o !== CW'(3)) begin
            n_fail++; $display("FAIL basic_count3: got %0d want 3", count_o);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b0, 1'b1, VLEN'(32'h100 + 4 * i), 1'(i), 1'b0, 1'b0);
            n_tests++;
            if (obs !== expv || bht_update_o.valid !== 1'b1 ||
                bht_update_o.pc !== VLEN'(32'h100 + 4 * i) || update_gbp_pred_o !== 4'b1111 ||
                update_lbp_pred_o !== 4'b1010) begin
                n_fail++; $display("FAIL basic_update%0d: got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (count_o !== '0) begin
            n_fail++; $display("FAIL basic_count0: got %0d want 0", count_o);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, VLEN'(32'h1000 + 4 * i), PW'($urandom), PW'($urandom), 1'($urandom),
                 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (push_ready_o !== 1'b0 || count_o !== CW'(DEPTH)) begin
            n_fail++; $display("FAIL full_state: got ready=%0b cnt=%0d want ready=0 cnt=%0d",
                               push_ready_o, count_o, DEPTH);
        end
        step(1'b1, 32'h2000, '0, '0, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs !== expv || count_o !== CW'(DEPTH - 1) || bht_update_o.valid !== 1'b1) begin
            n_fail++; $display("FAIL full_push_pop: got %h want %h", obs, expv);
        end
        step(1'b1, 32'h3000, 4'b0101, 4'b0011, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (count_o !== CW'(DEPTH) || push_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ninth: got cnt=%0d want %0d", count_o, DEPTH);
        end
        while (model_q.size() != 0) begin
            step(1'b0, '0, '0, '0, 1'b0, 1'b1, model_q[0].pc, 1'($urandom), 1'b0, 1'b0);
            n_tests++;
            if (obs !== expv || bht_update_o.valid !== 1'b1) begin
                n_fail++; $display("FAIL full_drain: got %h want %h", obs, expv);
            end
        end
        n_tests++;
        if (bht_update_o.pc !== 32'h3000 || update_is_unaligned_o !== 1'b1) begin
            n_fail++; $display("FAIL full_wrap_last: got pc=%h want 3000", bht_update_o.pc);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (underflow_o !== 1'b1 || bht_update_o.valid !== 1'b0 || count_o !== '0 || obs !== expv) begin
            n_fail++; $display("FAIL underflow_pulse: got %h want %h", obs, expv);
        end
        idle();
        n_tests++;
        if (underflow_o !== 1'b0 || obs !== expv) begin
            n_fail++; $display("FAIL underflow_clear: got %0b want 0", underflow_o);
        end
    endtask

    task automatic test_mismatch();
        step(1'b1, 32'h200, 4'b1100, 4'b0110, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (mismatch_o !== 1'b1 || bht_update_o.valid !== 1'b0 || count_o !== '0 || obs !== expv) begin
            n_fail++; $display("FAIL mismatch_pulse: got %h want %h", obs, expv);
        end
        idle();
        n_tests++;
        if (mismatch_o !== 1'b0) begin
            n_fail++; $display("FAIL mismatch_clear: got %0b want 0", mismatch_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++)
            step(1'b1, VLEN'(32'h400 + 4 * i), '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h500, '0, '0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (count_o !== '0 || push_ready_o !== 1'b1 || bht_update_o.valid !== 1'b0 ||
            mismatch_o !== 1'b0 || underflow_o !== 1'b0 || obs !== expv) begin
            n_fail++; $display("FAIL flush_state: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_debug();
        step(1'b1, 32'h600, 4'b1111, 4'b1111, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 32'h600, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (bht_update_o.valid !== 1'b0 || mismatch_o !== 1'b0 || count_o !== '0 || obs !== expv) begin
            n_fail++; $display("FAIL debug_gate: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h700, 4'b1111, 4'b0001, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h704, 4'b1111, 4'b0001, 1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bht_update_o.valid !== 1'b1 || obs !== expv) begin
            n_fail++; $display("FAIL async_pre: got %h want %h", obs, expv);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if (obs !== OW'(1)) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", obs, OW'(1));
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
        n_tests++;
        if (obs !== expv || count_o !== '0) begin
            n_fail++; $display("FAIL async_restart: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_random();
        logic [VLEN-1:0] rpc;
        for (int i = 0; i < 300; i++) begin
            if (model_q.size() != 0 && $urandom_range(3) != 0) rpc = model_q[0].pc;
            else rpc = $urandom;
            step(1'($urandom), $urandom, PW'($urandom), PW'($urandom), 1'($urandom),
                 1'($urandom), rpc, 1'($urandom), ($urandom_range(7) == 0),
                 ($urandom_range(39) == 0));
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_mismatch();
        test_flush();
        test_debug();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
